// File: rtl/wb_alu_initiator.sv
// wb_alu_initiator
// Wishbone initiator that runs one ALU transaction on the operand/opcode/result
// register peripheral for a local client: write A, B and OPCODE, wait for the
// result to settle, read RESULT_LO and RESULT_HI, then hand back a 64-bit
// result on a valid/ready port. Only one transaction is in flight at a time.
//
// Build option: define WB_INIT_TIMEOUT_EN to abort a transaction when any bus
// access waits TIMEOUT_CYCLES for its ack; the response then carries
// rsp_err = 1 and rsp_data = 0. Without it the block waits for ack forever and
// rsp_err is tied low.
//
// SETTLE_CYCLES must be at least 1.
module wb_alu_initiator #(
  parameter logic [31:0] BASE_ADDRESS   = 32'h3000_0000,
  parameter logic [31:0] A_ADDRESS      = BASE_ADDRESS + 32'd0,
  parameter logic [31:0] RES_LO_ADDRESS = BASE_ADDRESS + 32'd8,
  parameter logic [31:0] B_ADDRESS      = BASE_ADDRESS + 32'd12,
  parameter logic [31:0] OPCODE_ADDRESS = BASE_ADDRESS + 32'd16,
  parameter logic [31:0] RES_HI_ADDRESS = BASE_ADDRESS + 32'd20,
  parameter int          SETTLE_CYCLES  = 2,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  input  logic [3:0]  cmd_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_data,
  output logic        rsp_err,
  output logic        busy,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [31:0] o_wb_addr,
  output logic [31:0] o_wb_data,
  output logic [3:0]  o_wb_sel,
  input  logic        i_wb_ack,
  input  logic        i_wb_stall,
  input  logic [31:0] i_wb_data
);

  // One counter serves both the settle delay and the ack timeout; the two
  // never run at the same time, so it is sized for the larger of the two.
  localparam int CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
`ifdef WB_INIT_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WR_A   = 3'd1,
    ST_WR_B   = 3'd2,
    ST_WR_OP  = 3'd3,
    ST_SETTLE = 3'd4,
    ST_RD_LO  = 3'd5,
    ST_RD_HI  = 3'd6,
    ST_RESP   = 3'd7
  } state_t;

  state_t            state_r,     state_n;
  logic              cyc_r,       cyc_n;
  logic              stb_r,       stb_n;
  logic              we_r,        we_n;
  logic [31:0]       addr_r,      addr_n;
  logic [31:0]       wdata_r,     wdata_n;
  logic [31:0]       a_r,         a_n;
  logic [31:0]       b_r,         b_n;
  logic [3:0]        op_r,        op_n;
  logic [31:0]       res_lo_r,    res_lo_n;
  logic [31:0]       res_hi_r,    res_hi_n;
  logic              rsp_valid_r, rsp_valid_n;
  logic              err_r,       err_n;
  logic [CNT_W-1:0]  cnt_r,       cnt_n;
  logic              cmd_ready_r, cmd_ready_n;
  logic              busy_r,      busy_n;

  // Access descriptor for the bus state we are in
  logic              acc_we_s;
  logic [31:0]       acc_addr_s;
  logic [31:0]       acc_data_s;

  // Decode address, direction and write data of the access owned by each bus state
  always_comb begin
    acc_we_s   = 1'b1;
    acc_addr_s = A_ADDRESS;
    acc_data_s = a_r;
    case (state_r)
      ST_WR_A: begin
        acc_we_s   = 1'b1;
        acc_addr_s = A_ADDRESS;
        acc_data_s = a_r;
      end
      ST_WR_B: begin
        acc_we_s   = 1'b1;
        acc_addr_s = B_ADDRESS;
        acc_data_s = b_r;
      end
      ST_WR_OP: begin
        acc_we_s   = 1'b1;
        acc_addr_s = OPCODE_ADDRESS;
        acc_data_s = {28'h000_0000, op_r};
      end
      ST_RD_LO: begin
        acc_we_s   = 1'b0;
        acc_addr_s = RES_LO_ADDRESS;
        acc_data_s = 32'h0000_0000;
      end
      ST_RD_HI: begin
        acc_we_s   = 1'b0;
        acc_addr_s = RES_HI_ADDRESS;
        acc_data_s = 32'h0000_0000;
      end
      default: begin
        acc_we_s   = 1'b1;
        acc_addr_s = A_ADDRESS;
        acc_data_s = a_r;
      end
    endcase
  end

  // Next-state and next-output logic of the transaction sequencer
  always_comb begin
    state_n     = state_r;
    cyc_n       = cyc_r;
    stb_n       = stb_r;
    we_n        = we_r;
    addr_n      = addr_r;
    wdata_n     = wdata_r;
    a_n         = a_r;
    b_n         = b_r;
    op_n        = op_r;
    res_lo_n    = res_lo_r;
    res_hi_n    = res_hi_r;
    rsp_valid_n = rsp_valid_r;
    err_n       = err_r;
    cnt_n       = cnt_r;

    case (state_r)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_r) begin
          a_n      = cmd_a;
          b_n      = cmd_b;
          op_n     = cmd_op;
          res_lo_n = 32'h0000_0000;
          res_hi_n = 32'h0000_0000;
          err_n    = 1'b0;
          // The A write goes out right away, in the cycle after the handshake
          cyc_n    = 1'b1;
          stb_n    = 1'b1;
          we_n     = 1'b1;
          addr_n   = A_ADDRESS;
          wdata_n  = cmd_a;
          cnt_n    = '0;
          state_n  = ST_WR_A;
        end else begin
          state_n  = ST_IDLE;
        end
      end

      ST_WR_A, ST_WR_B, ST_WR_OP, ST_RD_LO, ST_RD_HI: begin
        if (!cyc_r) begin
          // Bus was idle for at least one cycle: launch this state's access.
          // Acks seen while cyc is low are strays and fall through here.
          cyc_n   = 1'b1;
          stb_n   = 1'b1;
          we_n    = acc_we_s;
          addr_n  = acc_addr_s;
          wdata_n = acc_data_s;
          cnt_n   = '0;
        end else if (i_wb_ack) begin
          // Ack closes the access, even if it arrives with the strobe
          cyc_n = 1'b0;
          stb_n = 1'b0;
          cnt_n = '0;
          case (state_r)
            ST_WR_A:  state_n = ST_WR_B;
            ST_WR_B:  state_n = ST_WR_OP;
            ST_WR_OP: state_n = ST_SETTLE;
            ST_RD_LO: begin
              res_lo_n = i_wb_data;
              state_n  = ST_RD_HI;
            end
            ST_RD_HI: begin
              res_hi_n = i_wb_data;
              state_n  = ST_RESP;
            end
            default:  state_n = ST_IDLE;
          endcase
`ifdef WB_INIT_TIMEOUT_EN
        end else if (cnt_r == TIMEOUT_LAST) begin
          // Responder never answered: abandon the rest of the transaction
          cyc_n    = 1'b0;
          stb_n    = 1'b0;
          cnt_n    = '0;
          res_lo_n = 32'h0000_0000;
          res_hi_n = 32'h0000_0000;
          err_n    = 1'b1;
          state_n  = ST_RESP;
`endif
        end else begin
          // Strobe is held until the responder samples it without stall
          if (stb_r && !i_wb_stall) begin
            stb_n = 1'b0;
          end else begin
            stb_n = stb_r;
          end
`ifdef WB_INIT_TIMEOUT_EN
          cnt_n = cnt_r + 1'b1;
`else
          cnt_n = cnt_r;
`endif
        end
      end

      ST_SETTLE: begin
        // Give the peripheral time to update its result after the opcode write
        if (cnt_r == SETTLE_LAST) begin
          cnt_n   = '0;
          state_n = ST_RD_LO;
        end else begin
          cnt_n   = cnt_r + 1'b1;
        end
      end

      ST_RESP: begin
        if (!rsp_valid_r) begin
          rsp_valid_n = 1'b1;
        end else if (rsp_ready) begin
          rsp_valid_n = 1'b0;
          state_n     = ST_IDLE;
        end else begin
          rsp_valid_n = 1'b1;
        end
      end

      default: begin
        cyc_n       = 1'b0;
        stb_n       = 1'b0;
        rsp_valid_n = 1'b0;
        state_n     = ST_IDLE;
      end
    endcase

    cmd_ready_n = (state_n == ST_IDLE);
    busy_n      = (state_n != ST_IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      cyc_r       <= 1'b0;
      stb_r       <= 1'b0;
      we_r        <= 1'b0;
      addr_r      <= 32'h0000_0000;
      wdata_r     <= 32'h0000_0000;
      a_r         <= 32'h0000_0000;
      b_r         <= 32'h0000_0000;
      op_r        <= 4'h0;
      res_lo_r    <= 32'h0000_0000;
      res_hi_r    <= 32'h0000_0000;
      rsp_valid_r <= 1'b0;
      err_r       <= 1'b0;
      cnt_r       <= '0;
      cmd_ready_r <= 1'b1;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_n;
      cyc_r       <= cyc_n;
      stb_r       <= stb_n;
      we_r        <= we_n;
      addr_r      <= addr_n;
      wdata_r     <= wdata_n;
      a_r         <= a_n;
      b_r         <= b_n;
      op_r        <= op_n;
      res_lo_r    <= res_lo_n;
      res_hi_r    <= res_hi_n;
      rsp_valid_r <= rsp_valid_n;
      err_r       <= err_n;
      cnt_r       <= cnt_n;
      cmd_ready_r <= cmd_ready_n;
      busy_r      <= busy_n;
    end
  end

  assign cmd_ready = cmd_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = {res_hi_r, res_lo_r};
`ifdef WB_INIT_TIMEOUT_EN
  assign rsp_err   = err_r;
`else
  assign rsp_err   = 1'b0;
`endif
  assign busy      = busy_r;
  assign o_wb_cyc  = cyc_r;
  assign o_wb_stb  = stb_r;
  assign o_wb_we   = we_r;
  assign o_wb_addr = addr_r;
  assign o_wb_data = wdata_r;
  assign o_wb_sel  = 4'hF;

endmodule
